// File: rtl/adc_pkg.sv
// Shared types, default frame geometry and sign-extension helper for the ADC frame capture.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam int unsigned DEF_FRAME_BITS = 34;
  localparam int unsigned DEF_N_CH       = 2;
  localparam int unsigned DEF_CH_BITS    = 14;
  localparam int unsigned DEF_LEAD_BITS  = 2;
  localparam int unsigned DEF_GAP_BITS   = 2;
  localparam int unsigned DEF_OUT_BITS   = 16;
  localparam int unsigned DEF_DROP_W     = 16;

  // Widest field/output the helper can handle.
  localparam int unsigned SEXT_MAX = 64;

  // Sign-extend the low ch_bits of field up to out_bits; bits at and above out_bits are zero.
  function automatic logic [SEXT_MAX-1:0] sext(input logic [SEXT_MAX-1:0] field,
                                               input int unsigned        ch_bits,
                                               input int unsigned        out_bits);
    logic [SEXT_MAX-1:0] ext_mask;
    logic [SEXT_MAX-1:0] keep_mask;
    logic [SEXT_MAX-1:0] base;
    ext_mask  = ~((SEXT_MAX'(1) << ch_bits) - SEXT_MAX'(1));
    keep_mask = (out_bits >= SEXT_MAX) ? '1 : ((SEXT_MAX'(1) << out_bits) - SEXT_MAX'(1));
    base      = field & ~ext_mask;
    if ((field & (SEXT_MAX'(1) << (ch_bits - 1))) != '0) begin
      return (base | ext_mask) & keep_mask;
    end
    return base & keep_mask;
  endfunction

endpackage

// File: rtl/adc_frame_capture_if.sv
// ADC serial input and FIFO write-port signals of the frame capture block.
interface adc_frame_capture_if import adc_pkg::*; #(
  parameter int unsigned DIN_W = DEF_N_CH * DEF_OUT_BITS
) ();

  logic             conv;
  logic             sdo;
  logic             full;
  logic [DIN_W-1:0] din;
  logic             wr_en;

  modport master (
    input  conv,
    input  sdo,
    input  full,
    output din,
    output wr_en
  );

  modport slave (
    output conv,
    output sdo,
    output full,
    input  din,
    input  wr_en
  );

endinterface

// File: rtl/adc_chan_unpack.sv
// Combinational unpack of a completed serial frame into packed, sign-extended channel samples.
module adc_chan_unpack import adc_pkg::*; #(
  parameter int unsigned FRAME_BITS = DEF_FRAME_BITS,
  parameter int unsigned N_CH       = DEF_N_CH,
  parameter int unsigned CH_BITS    = DEF_CH_BITS,
  parameter int unsigned LEAD_BITS  = DEF_LEAD_BITS,
  parameter int unsigned GAP_BITS   = DEF_GAP_BITS,
  parameter int unsigned OUT_BITS   = DEF_OUT_BITS
) (
  input  logic [FRAME_BITS-1:0]    frame,
  output logic [N_CH*OUT_BITS-1:0] din_c
);

  // Lead, gap and trailing bits carry no sample data.
  logic frame_unused;
  assign frame_unused = ^frame;

  // Frame bit 0 is the first bit shifted in, so it sits at the register MSB.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    localparam int unsigned POS = LEAD_BITS + 32'(k) * (CH_BITS + GAP_BITS);
    localparam int unsigned LSB = FRAME_BITS - POS - CH_BITS;

    logic [SEXT_MAX-1:0] ext;
    logic                ext_unused;

    assign ext        = sext(SEXT_MAX'(frame[LSB +: CH_BITS]), CH_BITS, OUT_BITS);
    assign din_c[k*OUT_BITS +: OUT_BITS] = ext[OUT_BITS-1:0];
    assign ext_unused = ^ext;
  end

endmodule

// File: rtl/adc_frame_capture.sv
// Serial ADC frame capture: deserialise, decimate and write packed samples to the FIFO.
module adc_frame_capture import adc_pkg::*; #(
  parameter int unsigned FRAME_BITS = DEF_FRAME_BITS,
  parameter int unsigned N_CH       = DEF_N_CH,
  parameter int unsigned CH_BITS    = DEF_CH_BITS,
  parameter int unsigned LEAD_BITS  = DEF_LEAD_BITS,
  parameter int unsigned GAP_BITS   = DEF_GAP_BITS,
  parameter int unsigned OUT_BITS   = DEF_OUT_BITS,
  parameter int unsigned DROP_W     = DEF_DROP_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [7:0]          decim,
  input  logic                clr_stat,
  adc_frame_capture_if.master bus,
  output logic [DROP_W-1:0]   drop_cnt,
  output logic                frame_err
);

  localparam int unsigned DIN_W = N_CH * OUT_BITS;
  localparam int unsigned CNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  // Reject frame layouts that do not fit or cannot be represented.
  if (LEAD_BITS + N_CH * CH_BITS + (N_CH - 1) * GAP_BITS > FRAME_BITS) begin : g_bad_layout
    $error("adc_frame_capture: channel fields exceed FRAME_BITS");
  end
  if (OUT_BITS < CH_BITS || OUT_BITS > SEXT_MAX) begin : g_bad_out
    $error("adc_frame_capture: OUT_BITS out of range");
  end

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   sreg_q, sreg_d;
  logic [7:0]              decim_cnt_q, decim_cnt_d;
  logic [DIN_W-1:0]        din_d;
  logic [DIN_W-1:0]        unpacked_c;
  logic                    wr_en_d;
  logic [DROP_W-1:0]       drop_d;
  logic                    err_d;

  adc_chan_unpack #(
    .FRAME_BITS (FRAME_BITS),
    .N_CH       (N_CH),
    .CH_BITS    (CH_BITS),
    .LEAD_BITS  (LEAD_BITS),
    .GAP_BITS   (GAP_BITS),
    .OUT_BITS   (OUT_BITS)
  ) u_unpack (
    .frame (sreg_q),
    .din_c (unpacked_c)
  );

  // Next-state, datapath and statistics update.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sreg_d      = sreg_q;
    decim_cnt_d = decim_cnt_q;
    din_d       = bus.din;
    wr_en_d     = 1'b0;
    drop_d      = drop_cnt;
    err_d       = frame_err;

    case (state_q)
      IDLE: begin
        if (bus.conv && enable) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (bus.conv) begin
          // Restart on a premature strobe; the partial frame is overwritten.
          err_d     = 1'b1;
          bit_cnt_d = '0;
        end else begin
          sreg_d = {sreg_q[FRAME_BITS-2:0], bus.sdo};
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = DONE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        // >= lets a lowered decim take effect on the very next frame.
        if (decim_cnt_q >= decim) begin
          decim_cnt_d = '0;
          if (!bus.full) begin
            din_d   = unpacked_c;
            wr_en_d = 1'b1;
          end else if (drop_cnt != '1) begin
            drop_d = drop_cnt + DROP_W'(1);
          end
        end else begin
          decim_cnt_d = decim_cnt_q + 8'd1;
        end
        if (bus.conv && enable) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr_stat) begin
      drop_d = '0;
      err_d  = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sreg_q      <= '0;
      decim_cnt_q <= '0;
      bus.din     <= '0;
      bus.wr_en   <= 1'b0;
      drop_cnt    <= '0;
      frame_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sreg_q      <= sreg_d;
      decim_cnt_q <= decim_cnt_d;
      bus.din     <= din_d;
      bus.wr_en   <= wr_en_d;
      drop_cnt    <= drop_d;
      frame_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_adc_frame_capture.sv
// Scoreboard bench for adc_frame_capture: default 2-channel instance and a 4-channel, DROP_W=2 instance.
module tb_adc_frame_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, clr_a, err_a;
  logic [7:0]  decim_a;
  logic [15:0] drop_a;
  logic        en_b, clr_b, err_b;
  logic [7:0]  decim_b;
  logic [1:0]  drop_b;

  adc_frame_capture_if #(.DIN_W(32)) bus_a ();
  adc_frame_capture_if #(.DIN_W(64)) bus_b ();

  adc_frame_capture dut_a (
    .clk       (clk),
    .rst       (rst),
    .enable    (en_a),
    .decim     (decim_a),
    .clr_stat  (clr_a),
    .bus       (bus_a),
    .drop_cnt  (drop_a),
    .frame_err (err_a)
  );

  adc_frame_capture #(
    .FRAME_BITS (48),
    .N_CH       (4),
    .CH_BITS    (12),
    .LEAD_BITS  (0),
    .GAP_BITS   (0),
    .OUT_BITS   (16),
    .DROP_W     (2)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .enable    (en_b),
    .decim     (decim_b),
    .clr_stat  (clr_b),
    .bus       (bus_b),
    .drop_cnt  (drop_b),
    .frame_err (err_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] qa_d[$];
  int          qa_c[$];
  logic [63:0] qb_d[$];
  int          qb_c[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [33:0] mk_a(input logic [13:0] c0, input logic [13:0] c1);
    return {2'b11, c0, 2'b10, c1, 2'b01};
  endfunction

  function automatic logic [31:0] exp_a(input logic [13:0] c0, input logic [13:0] c1);
    return {{2{c1[13]}}, c1, {2{c0[13]}}, c0};
  endfunction

  // Strobe conv, then present nbits of f MSB first; returns at the negedge after the last bit.
  task automatic send_a(input logic [33:0] f, input int nbits, input bit push, input logic [31:0] exp);
    bus_a.conv = 1'b1;
    @(negedge clk);
    bus_a.conv = 1'b0;
    if (push) begin
      qa_d.push_back(exp);
      qa_c.push_back(cyc + 35);
    end
    for (int i = 0; i < nbits; i++) begin
      bus_a.sdo = f[33-i];
      @(negedge clk);
    end
  endtask

  task automatic send_b(input logic [47:0] f, input bit push, input logic [63:0] exp);
    bus_b.conv = 1'b1;
    @(negedge clk);
    bus_b.conv = 1'b0;
    if (push) begin
      qb_d.push_back(exp);
      qb_c.push_back(cyc + 49);
    end
    for (int i = 0; i < 48; i++) begin
      bus_b.sdo = f[47-i];
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    bus_a.conv = 1'b0;
    bus_b.conv = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every write strobe must match the oldest expected word, data and cycle.
  always @(negedge clk) begin
    if (bus_a.wr_en === 1'b1) begin
      n_cmp++;
      if (qa_d.size() == 0) begin
        n_err++;
        $display("FAIL wr_a_unexpected: din %h at cycle %0d, no write expected", bus_a.din, cyc);
      end else begin
        logic [31:0] d;
        int          c;
        d = qa_d.pop_front();
        c = qa_c.pop_front();
        if (bus_a.din !== d || cyc != c) begin
          n_err++;
          $display("FAIL wr_a: din %h cycle %0d, expected din %h cycle %0d", bus_a.din, cyc, d, c);
        end
      end
    end
    if (bus_b.wr_en === 1'b1) begin
      n_cmp++;
      if (qb_d.size() == 0) begin
        n_err++;
        $display("FAIL wr_b_unexpected: din %h at cycle %0d, no write expected", bus_b.din, cyc);
      end else begin
        logic [63:0] d;
        int          c;
        d = qb_d.pop_front();
        c = qb_c.pop_front();
        if (bus_b.din !== d || cyc != c) begin
          n_err++;
          $display("FAIL wr_b: din %h cycle %0d, expected din %h cycle %0d", bus_b.din, cyc, d, c);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    en_a = 1'b0; clr_a = 1'b0; decim_a = 8'd0;
    en_b = 1'b0; clr_b = 1'b0; decim_b = 8'd0;
    bus_a.conv = 1'b0; bus_a.sdo = 1'b0; bus_a.full = 1'b0;
    bus_b.conv = 1'b0; bus_b.sdo = 1'b0; bus_b.full = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_din_a",   64'(bus_a.din), 64'd0);
    chk("rst_wr_en_a", 64'(bus_a.wr_en), 64'd0);
    chk("rst_drop_a",  64'(drop_a), 64'd0);
    chk("rst_err_a",   64'(err_a), 64'd0);
    chk("rst_din_b",   bus_b.din, 64'd0);
    chk("rst_drop_b",  64'(drop_b), 64'd0);

    rst = 1'b1;
    en_a = 1'b1;
    en_b = 1'b1;
    @(negedge clk);

    // Basic frame from the reference vector.
    send_a({2'b00, 14'h1FFF, 2'b00, 14'h2000, 2'b00}, 34, 1'b1, 32'hE000_1FFF);
    idle(3);

    // decim=3 over 8 back-to-back frames: frames 4 and 8 are written.
    decim_a = 8'd3;
    for (int f = 1; f <= 8; f++) begin
      logic [13:0] c0, c1;
      c0 = 14'h0A50 + 14'(f);
      c1 = 14'h2A00 + 14'(f);
      send_a(mk_a(c0, c1), 34, (f % 4) == 0, exp_a(c0, c1));
    end
    idle(3);
    decim_a = 8'd0;

    // FIFO full across 3 kept frames, then clear.
    bus_a.full = 1'b1;
    for (int f = 0; f < 3; f++) send_a(mk_a(14'h0111, 14'h0222), 34, 1'b0, 32'd0);
    idle(2);
    bus_a.full = 1'b0;
    chk("full_drop_a", 64'(drop_a), 64'd3);
    chk("full_err_a",  64'(err_a), 64'd0);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    chk("clr_drop_a", 64'(drop_a), 64'd0);

    // conv re-asserted after 20 bits: aborted frame not written, new one is.
    send_a(mk_a(14'h0AAA, 14'h1555), 20, 1'b0, 32'd0);
    send_a(mk_a(14'h3000, 14'h0001), 34, 1'b1, 32'h0001_F000);
    idle(3);
    chk("restart_err_a", 64'(err_a), 64'd1);

    // One drop, then reset mid-frame clears everything.
    bus_a.full = 1'b1;
    send_a(mk_a(14'h0123, 14'h0456), 34, 1'b0, 32'd0);
    idle(2);
    bus_a.full = 1'b0;
    chk("pre_rst_drop_a", 64'(drop_a), 64'd1);
    send_a(mk_a(14'h1234, 14'h0567), 10, 1'b0, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_din_a",   64'(bus_a.din), 64'd0);
    chk("midrst_wr_en_a", 64'(bus_a.wr_en), 64'd0);
    chk("midrst_drop_a",  64'(drop_a), 64'd0);
    chk("midrst_err_a",   64'(err_a), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_a(mk_a(14'h2345, 14'h1ABC), 34, 1'b1, 32'h1ABC_E345);
    idle(3);
    chk("post_rst_err_a", 64'(err_a), 64'd0);

    // Four-channel instance, back-to-back frames.
    send_b({12'h800, 12'h7FF, 12'hFFF, 12'h001}, 1'b1, 64'h0001_FFFF_07FF_F800);
    send_b({12'h123, 12'hABC, 12'h000, 12'h9A5}, 1'b1, 64'hF9A5_0000_FABC_0123);
    idle(3);

    // Two-bit drop counter saturates after 5 drops.
    bus_b.full = 1'b1;
    for (int f = 0; f < 5; f++) send_b({12'h111, 12'h222, 12'h333, 12'h444}, 1'b0, 64'd0);
    idle(2);
    bus_b.full = 1'b0;
    chk("sat_drop_b", 64'(drop_b), 64'd3);
    chk("sat_err_b",  64'(err_b), 64'd0);
    clr_b = 1'b1;
    @(negedge clk);
    clr_b = 1'b0;
    chk("clr_drop_b", 64'(drop_b), 64'd0);

    idle(5);
    chk("pending_a", 64'(qa_d.size()), 64'd0);
    chk("pending_b", 64'(qb_d.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
